// File: rtl/div_operand_feeder.sv
// Operand feeder for the fixed-point divider: buffers operand pairs in a small
// FIFO and launches them one at a time, with a watchdog for a stuck divider.
module div_operand_feeder #(
   parameter int W       = 10,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_a,
   input  logic [W-1:0]             in_b,
   output logic [W-1:0]             div_a,
   output logic [W-1:0]             div_b,
   output logic                     div_start,
   output logic                     div_sclr,
   input  logic                     div_busy,
   input  logic                     div_valid,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [7:0]               jobs_done,
   output logic                     timeout_err,
   output logic                     idle
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] WDOG_LAST  = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_CLEAR  = 2'd3
   } state_t;

   state_t          state;
   logic [W-1:0]    mem_a [DEPTH];
   logic [W-1:0]    mem_b [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   wdog;
   logic            full;
   logic            push;
   logic            pop;
   logic            unused;

   // Handshake: a pair transfers on any rising edge where in_valid && in_ready;
   // in_ready depends only on registered occupancy, never on in_valid.
   assign full     = (fifo_level == FULL_LEVEL);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   // Pop decision uses the pre-edge level, so a pair is never popped in its push cycle.
   assign pop      = (state == S_IDLE) && (fifo_level != '0);
   assign idle     = (state == S_IDLE) && (fifo_level == '0);

   // Busy is status only; sequencing is driven purely by div_valid and the watchdog.
   assign unused   = div_busy;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= in_a;
         mem_b[wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         div_a       <= '0;
         div_b       <= '0;
         div_start   <= 1'b0;
         div_sclr    <= 1'b0;
         wdog        <= '0;
         jobs_done   <= '0;
         timeout_err <= 1'b0;
      end else begin
         div_start <= 1'b0;
         div_sclr  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  div_a     <= mem_a[rd_ptr];
                  div_b     <= mem_b[rd_ptr];
                  div_start <= 1'b1;
                  state     <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               wdog  <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // A result arriving on the expiry cycle still counts as a completion.
               if (div_valid) begin
                  jobs_done <= jobs_done + 8'd1;
                  state     <= S_IDLE;
               end else if (wdog == WDOG_LAST) begin
                  timeout_err <= 1'b1;
                  div_sclr    <= 1'b1;
                  state       <= S_CLEAR;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_CLEAR: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
